sa_credit_stage: RTL and testbench

SA_CREDIT_STAGE -- requirements
Module: sa_credit_stage

---
 rtl/noc_pkg.sv | 6 +
 rtl/credit_counter.sv | 29 ++
 rtl/sa_credit_stage.sv | 78 +++++++
 tb/tb_sa_credit_stage.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared router defaults for the switch-allocation credit stage
package noc_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int BUF_DEPTH_DEF = 4;
  localparam int CNT_W         = $clog2(BUF_DEPTH_DEF + 1);
endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - per-output credit counter saturating at the downstream buffer depth
module credit_counter
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  // A return and a spend on the same edge cancel, so only a lone return can overflow.
  assign overflow = inc & ~dec & (count == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= FULL;
    end else if (inc && !dec && count != FULL) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/sa_credit_stage.sv
// rtl/sa_credit_stage.sv - request masking, grant legality check, credits and xbar select registers
module sa_credit_stage
  import noc_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              in_valid,
  input  logic [NUM_PORTS-1:0]              in_route   [NUM_PORTS-1:0],
  output logic [NUM_PORTS-1:0]              requests   [NUM_PORTS-1:0],
  input  logic [NUM_PORTS-1:0]              grants     [NUM_PORTS-1:0],
  input  logic [NUM_PORTS-1:0]              credit_in,
  output logic [NUM_PORTS-1:0]              deq,
  output logic [NUM_PORTS-1:0]              xbar_sel   [NUM_PORTS-1:0],
  output logic [NUM_PORTS-1:0]              xbar_valid,
  output logic [$clog2(BUF_DEPTH+1)-1:0]    credit_cnt [NUM_PORTS-1:0],
  output logic                              err_grant,
  output logic                              err_credit
);
  logic [NUM_PORTS-1:0] gcol [NUM_PORTS-1:0];
  logic [NUM_PORTS-1:0] cnt_ok;
  logic [NUM_PORTS-1:0] col_grant;
  logic [NUM_PORTS-1:0] overflow;
  logic                 legal;

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    assign cnt_ok[j] = (credit_cnt[j] != '0);

    credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
      .clk      (clk),
      .reset    (reset),
      .inc      (credit_in[j]),
      .dec      (col_grant[j]),
      .count    (credit_cnt[j]),
      .overflow (overflow[j])
    );
  end

  // Requests are masked during reset, so any nonzero grant then is illegal and nothing moves.
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < NUM_PORTS; i++) begin
      requests[i] = '0;
      gcol[i]     = '0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        requests[i][j] = reset & in_valid[i] & $onehot(in_route[i]) & in_route[i][j] & cnt_ok[j];
        gcol[j][i]     = grants[i][j];
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if ($countones(grants[i]) > 1) legal = 1'b0;
      if ((grants[i] & ~requests[i]) != '0) legal = 1'b0;
      if ($countones(gcol[i]) > 1) legal = 1'b0;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      deq[i]       = legal & (|grants[i]);
      col_grant[i] = legal & (|gcol[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NUM_PORTS; j++) xbar_sel[j] <= '0;
      xbar_valid <= '0;
      err_grant  <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      for (int j = 0; j < NUM_PORTS; j++) xbar_sel[j] <= col_grant[j] ? gcol[j] : '0;
      xbar_valid <= col_grant;
      err_grant  <= err_grant | ~legal;
      err_credit <= err_credit | (|overflow);
    end
  end
endmodule

// File: tb/tb_sa_credit_stage.sv
// tb/tb_sa_credit_stage.sv - directed and randomized checks of sa_credit_stage against a credit model
module tb_sa_credit_stage;
  localparam int N  = 4;
  localparam int BD = 4;
  localparam int W  = $clog2(BD + 1);

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_route [N-1:0];
  logic [N-1:0] requests [N-1:0];
  logic [N-1:0] grants   [N-1:0];
  logic [N-1:0] credit_in = '0;
  logic [N-1:0] deq;
  logic [N-1:0] xbar_sel [N-1:0];
  logic [N-1:0] xbar_valid;
  logic [W-1:0] credit_cnt [N-1:0];
  logic         err_grant, err_credit;

  int n_tests = 0;
  int n_fail  = 0;

  int           m_cred [N];
  bit           m_eg, m_ec;
  logic [N-1:0] m_xv;
  logic [N-1:0] m_sel [N];
  logic [N-1:0] exp_req [N];

  sa_credit_stage #(.NUM_PORTS(N), .BUF_DEPTH(BD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_route(in_route),
    .requests(requests), .grants(grants), .credit_in(credit_in), .deq(deq),
    .xbar_sel(xbar_sel), .xbar_valid(xbar_valid), .credit_cnt(credit_cnt),
    .err_grant(err_grant), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin m_cred[j] = BD; m_sel[j] = '0; end
    m_xv = '0; m_eg = 0; m_ec = 0;
  endtask

  task automatic clear_inputs();
    in_valid = '0; credit_in = '0;
    for (int i = 0; i < N; i++) begin in_route[i] = '0; grants[i] = '0; end
  endtask

  task automatic calc_req();
    for (int i = 0; i < N; i++) begin
      exp_req[i] = '0;
      if (in_valid[i] && $countones(in_route[i]) == 1)
        for (int j = 0; j < N; j++)
          if (in_route[i][j] && m_cred[j] > 0) exp_req[i][j] = 1'b1;
    end
  endtask

  function automatic bit model_legal();
    int cc [N];
    for (int j = 0; j < N; j++) cc[j] = 0;
    for (int i = 0; i < N; i++) begin
      int rc = 0;
      for (int j = 0; j < N; j++)
        if (grants[i][j]) begin
          rc++; cc[j]++;
          if (!exp_req[i][j]) return 0;
        end
      if (rc > 1) return 0;
    end
    for (int j = 0; j < N; j++) if (cc[j] > 1) return 0;
    return 1;
  endfunction

  function automatic logic [N-1:0] model_deq();
    logic [N-1:0] d = '0;
    if (model_legal()) for (int i = 0; i < N; i++) d[i] = |grants[i];
    return d;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit lg;
    calc_req();
    lg = model_legal();
    if (!lg) m_eg = 1;
    for (int j = 0; j < N; j++) begin
      int src = -1;
      if (lg) for (int i = 0; i < N; i++) if (grants[i][j]) src = i;
      m_xv[j]  = (src >= 0);
      m_sel[j] = (src >= 0) ? N'(1 << src) : '0;
      if (src >= 0 && credit_in[j]) ;
      else if (src >= 0) m_cred[j]--;
      else if (credit_in[j]) begin
        if (m_cred[j] == BD) m_ec = 1; else m_cred[j]++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = '1; credit_in = '1;
    for (int i = 0; i < N; i++) begin in_route[i] = 4'b0001; grants[i] = 4'b0001; end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #2;
      n_tests++; if (xbar_valid !== '0) begin n_fail++; $display("FAIL reset_xv got %b exp 0000", xbar_valid); end
      n_tests++; if (deq !== '0) begin n_fail++; $display("FAIL reset_deq got %b exp 0000", deq); end
      n_tests++; if ({err_grant, err_credit} !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b%b exp 00", err_grant, err_credit); end
      for (int j = 0; j < N; j++) begin
        n_tests++; if (credit_cnt[j] !== W'(BD)) begin n_fail++; $display("FAIL reset_cnt[%0d] got %0d exp %0d", j, credit_cnt[j], BD); end
        n_tests++; if (requests[j] !== '0 || xbar_sel[j] !== '0) begin n_fail++; $display("FAIL reset_req_sel[%0d] got %b/%b exp 0000/0000", j, requests[j], xbar_sel[j]); end
      end
    end
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    clear_inputs();
    in_valid = 4'b0001; in_route[0] = 4'b0100; grants[0] = 4'b0100;
    #1;
    n_tests++; if (requests[0] !== 4'b0100) begin n_fail++; $display("FAIL single_req got %b exp 0100", requests[0]); end
    n_tests++; if (deq !== 4'b0001) begin n_fail++; $display("FAIL single_deq got %b exp 0001", deq); end
    step();
    n_tests++; if (xbar_valid !== 4'b0100) begin n_fail++; $display("FAIL single_xv got %b exp 0100", xbar_valid); end
    n_tests++; if (xbar_sel[2] !== 4'b0001) begin n_fail++; $display("FAIL single_sel got %b exp 0001", xbar_sel[2]); end
    n_tests++; if (credit_cnt[2] !== W'(3)) begin n_fail++; $display("FAIL single_cnt got %0d exp 3", credit_cnt[2]); end
    clear_inputs(); credit_in = 4'b0100;
    step();
    n_tests++; if (xbar_valid !== '0 || xbar_sel[2] !== '0) begin n_fail++; $display("FAIL single_idle got %b/%b exp 0000/0000", xbar_valid, xbar_sel[2]); end
    clear_inputs();
  endtask

  task automatic test_drain();
    clear_inputs();
    in_valid = 4'b0010; in_route[1] = 4'b0010; grants[1] = 4'b0010;
    for (int k = 0; k < BD; k++) begin
      step();
      n_tests++; if (credit_cnt[1] !== W'(BD - 1 - k)) begin n_fail++; $display("FAIL drain_cnt got %0d exp %0d", credit_cnt[1], BD - 1 - k); end
    end
    grants[1] = '0; in_valid = '1;
    for (int i = 0; i < N; i++) in_route[i] = 4'b0010;
    #1;
    for (int i = 0; i < N; i++) begin
      n_tests++; if (requests[i][1] !== 1'b0) begin n_fail++; $display("FAIL drain_mask[%0d] got %b exp 0", i, requests[i][1]); end
    end
    clear_inputs(); credit_in = 4'b0010;
    for (int k = 0; k < BD; k++) step();
    n_tests++; if (credit_cnt[1] !== W'(BD)) begin n_fail++; $display("FAIL drain_refill got %0d exp %0d", credit_cnt[1], BD); end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    clear_inputs();
    in_valid = 4'b1000; in_route[3] = 4'b1000; grants[3] = 4'b1000;
    step(); step();
    credit_in = 4'b1000;
    step();
    n_tests++; if (credit_cnt[3] !== W'(2)) begin n_fail++; $display("FAIL simul_cnt got %0d exp 2", credit_cnt[3]); end
    n_tests++; if (xbar_valid[3] !== 1'b1) begin n_fail++; $display("FAIL simul_xv got %b exp 1", xbar_valid[3]); end
    clear_inputs(); credit_in = 4'b1000;
    step(); step();
    clear_inputs();
  endtask

  task automatic test_overflow();
    clear_inputs(); credit_in = 4'b0001;
    step();
    clear_inputs();
    n_tests++; if (credit_cnt[0] !== W'(BD)) begin n_fail++; $display("FAIL ovf_cnt got %0d exp %0d", credit_cnt[0], BD); end
    n_tests++; if (err_credit !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", err_credit); end
  endtask

  task automatic test_illegal();
    clear_inputs();
    in_valid = 4'b0011; in_route[0] = 4'b0001; in_route[1] = 4'b0001;
    grants[0] = 4'b0001; grants[1] = 4'b0001;
    #1;
    n_tests++; if (deq !== '0) begin n_fail++; $display("FAIL illegal_deq got %b exp 0000", deq); end
    step();
    clear_inputs();
    n_tests++; if (xbar_valid !== '0) begin n_fail++; $display("FAIL illegal_xv got %b exp 0000", xbar_valid); end
    n_tests++; if (credit_cnt[0] !== W'(BD)) begin n_fail++; $display("FAIL illegal_cnt got %0d exp %0d", credit_cnt[0], BD); end
    n_tests++; if (err_grant !== 1'b1) begin n_fail++; $display("FAIL illegal_err got %b exp 1", err_grant); end
    for (int k = 0; k < 10; k++) step();
    n_tests++; if (err_grant !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got %b exp 1", err_grant); end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    in_valid = 4'b0001; in_route[0] = 4'b0100; grants[0] = 4'b0100;
    step();
    #2 reset = 1'b0;
    #1;
    n_tests++; if (xbar_valid !== '0) begin n_fail++; $display("FAIL rstmid_xv got %b exp 0000", xbar_valid); end
    n_tests++; if (credit_cnt[2] !== W'(BD)) begin n_fail++; $display("FAIL rstmid_cnt got %0d exp %0d", credit_cnt[2], BD); end
    n_tests++; if ({err_grant, err_credit} !== 2'b00) begin n_fail++; $display("FAIL rstmid_err got %b%b exp 00", err_grant, err_credit); end
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step();
    n_tests++; if (xbar_valid !== 4'b0100 || credit_cnt[2] !== W'(BD - 1)) begin n_fail++; $display("FAIL rstmid_first got %b/%0d exp 0100/%0d", xbar_valid, credit_cnt[2], BD - 1); end
    clear_inputs(); credit_in = 4'b0100;
    step();
    clear_inputs();
  endtask

  task automatic test_random();
    logic [N-1:0] used, ed;
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      in_valid = N'($urandom);
      for (int i = 0; i < N; i++)
        in_route[i] = ($urandom_range(0, 9) < 8) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
      for (int j = 0; j < N; j++) credit_in[j] = ($urandom_range(0, 9) < 3);
      calc_req();
      used = '0;
      for (int k = 0; k < N; k++) begin
        int i = k;
        int js = $urandom_range(0, N - 1);
        bit done = 0;
        if ($urandom_range(0, 3) != 0)
          for (int m = 0; m < N; m++) begin
            int j = (js + m) % N;
            if (!done && exp_req[i][j] && !used[j]) begin grants[i][j] = 1'b1; used[j] = 1'b1; done = 1; end
          end
      end
      if ($urandom_range(0, 9) == 0) begin
        int ri = $urandom_range(0, N - 1);
        int rj = $urandom_range(0, N - 1);
        grants[ri][rj] = ~grants[ri][rj];
      end
      #1;
      ed = model_deq();
      for (int i = 0; i < N; i++) begin
        n_tests++; if (requests[i] !== exp_req[i]) begin n_fail++; $display("FAIL rnd_req[%0d] cyc %0d got %b exp %b", i, c, requests[i], exp_req[i]); end
      end
      n_tests++; if (deq !== ed) begin n_fail++; $display("FAIL rnd_deq cyc %0d got %b exp %b", c, deq, ed); end
      step();
      n_tests++; if (xbar_valid !== m_xv) begin n_fail++; $display("FAIL rnd_xv cyc %0d got %b exp %b", c, xbar_valid, m_xv); end
      for (int j = 0; j < N; j++) begin
        n_tests++; if (xbar_sel[j] !== m_sel[j]) begin n_fail++; $display("FAIL rnd_sel[%0d] cyc %0d got %b exp %b", j, c, xbar_sel[j], m_sel[j]); end
        n_tests++; if (credit_cnt[j] !== W'(m_cred[j])) begin n_fail++; $display("FAIL rnd_cnt[%0d] cyc %0d got %0d exp %0d", j, c, credit_cnt[j], m_cred[j]); end
      end
      n_tests++; if ({err_grant, err_credit} !== {m_eg, m_ec}) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b%b exp %b%b", c, err_grant, err_credit, m_eg, m_ec); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_single();
    test_drain();
    test_simultaneous();
    test_overflow();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
